// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the memory port arbiter: fetch port, load/store port and shared memory port.
// The arbiter takes the slave modport; the surrounding core/memory side takes master.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);
    localparam int unsigned BW = DW / 8;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic          if_err;
    logic [DW-1:0] if_rdata;

    logic          ls_req;
    logic          ls_we;
    logic [BW-1:0] ls_be;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_ack;
    logic          ls_err;
    logic [DW-1:0] ls_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    logic          owner;
    logic          busy;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  mem_ack, mem_rdata,
        output if_ack, if_err, if_rdata,
        output ls_ack, ls_err, ls_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output owner, busy
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output mem_ack, mem_rdata,
        input  if_ack, if_err, if_rdata,
        input  ls_ack, ls_err, ls_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  owner, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Load/store has priority; a streak limit keeps fetch from starving, a timer aborts dead memory.
module mem_port_arbiter #(
    parameter int unsigned AW           = 16,
    parameter int unsigned DW           = 16,
    parameter int unsigned LS_BURST_MAX = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int unsigned BW = DW / 8;
    localparam int unsigned SW = $clog2(LS_BURST_MAX + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] StreakMax = SW'(LS_BURST_MAX);
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIfBusy, StLsBusy, StDone} state_e;

    state_e        r_state;
    logic [SW-1:0] r_streak;
    logic [TW-1:0] r_timer;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [BW-1:0] r_mem_be;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_if_ack;
    logic          r_if_err;
    logic [DW-1:0] r_if_rdata;
    logic          r_ls_ack;
    logic          r_ls_err;
    logic [DW-1:0] r_ls_rdata;
    logic          r_owner;
    logic          r_busy;

    logic w_any_req;
    logic w_grant_ls;
    logic w_timeout;

    assign w_any_req  = bus.if_req || bus.ls_req;
    // Fetch only wins contention once load/store has used up its burst allowance.
    assign w_grant_ls = bus.ls_req && !(bus.if_req && (r_streak == StreakMax));
    assign w_timeout  = (TIMEOUT != 0) && (r_timer == TimerLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_streak    <= '0;
            r_timer     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_ack    <= 1'b0;
            r_ls_err    <= 1'b0;
            r_ls_rdata  <= '0;
            r_owner     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_mem_req <= 1'b1;
                        r_busy    <= 1'b1;
                        r_timer   <= '0;
                        if (w_grant_ls) begin
                            r_state     <= StLsBusy;
                            r_owner     <= 1'b1;
                            r_mem_we    <= bus.ls_we;
                            r_mem_be    <= bus.ls_be;
                            r_mem_addr  <= bus.ls_addr;
                            r_mem_wdata <= bus.ls_wdata;
                            if (!bus.if_req) begin
                                r_streak <= '0;
                            end else if (r_streak != StreakMax) begin
                                r_streak <= r_streak + SW'(1);
                            end
                        end else begin
                            r_state     <= StIfBusy;
                            r_owner     <= 1'b0;
                            r_mem_we    <= 1'b0;
                            r_mem_be    <= '1;
                            r_mem_addr  <= bus.if_addr;
                            r_mem_wdata <= '0;
                            r_streak    <= '0;
                        end
                    end
                end
                StIfBusy, StLsBusy: begin
                    // An acknowledge arriving on the final timer cycle still completes normally.
                    if (bus.mem_ack) begin
                        r_state   <= StDone;
                        r_mem_req <= 1'b0;
                        if (r_state == StLsBusy) begin
                            r_ls_ack   <= 1'b1;
                            r_ls_rdata <= bus.mem_rdata;
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= bus.mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_state   <= StDone;
                        r_mem_req <= 1'b0;
                        if (r_state == StLsBusy) begin
                            r_ls_err <= 1'b1;
                        end else begin
                            r_if_err <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                StDone: begin
                    r_state  <= StIdle;
                    r_busy   <= 1'b0;
                    r_if_ack <= 1'b0;
                    r_if_err <= 1'b0;
                    r_ls_ack <= 1'b0;
                    r_ls_err <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_ack    = r_if_ack;
    assign bus.if_err    = r_if_err;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.ls_ack    = r_ls_ack;
    assign bus.ls_err    = r_ls_err;
    assign bus.ls_rdata  = r_ls_rdata;
    assign bus.owner     = r_owner;
    assign bus.busy      = r_busy;

    // Requesters must hold req for the whole time their transaction owns the memory.
    if_req_held_a: assert property (@(posedge clk) disable iff (rst)
        (r_state == StIfBusy) |-> bus.if_req);
    ls_req_held_a: assert property (@(posedge clk) disable iff (rst)
        (r_state == StLsBusy) |-> bus.ls_req);
endmodule
